// File: rtl/rgb_led_arbiter.sv
// -----------------------------------------------------------------------------
// rgb_led_arbiter
//
// Shares one RGB LED among three requesters. Each requester asks for the LED
// with its req bit and supplies the colour it wants shown. Grants are handed
// out round-robin. A grant ends when its requester lets go of req or when it
// has lasted DWELL_CYCLES cycles, whichever comes first. Every grant is
// followed by a GAP_CYCLES-long dark gap, so a hand-over between requesters is
// always visible as a blink.
//
// Configuration macro:
//   LED_DIM_EN  when defined, a free-running 4-bit PWM counter dims the LED
//               to DUTY/16 brightness. When undefined, the LED runs at full
//               duty and no PWM counter is built.
//
// Parameters:
//   DWELL_CYCLES  maximum grant length in clk cycles (2 .. 2^24-1)
//   GAP_CYCLES    LED-off gap between grants in clk cycles (1 .. 2^24-1)
//   DUTY          on-count out of 16 when dimming is enabled (0 .. 16)
//
// Ports:
//   clk                     system clock; all state changes on its rising edge
//   rst                     asynchronous active-high reset
//   req[2:0]                per-requester request, bit i = requester i
//   color0/1/2[2:0]         requested colour {r,g,b} for each requester
//   gnt[2:0]                one-hot grant (registered), zero when no grant
//   red, green, blue        active-high LED drive; the pads invert these
//   busy                    high while serving a grant or in the gap
// -----------------------------------------------------------------------------
module rgb_led_arbiter #(
    parameter int unsigned DWELL_CYCLES = 12_000_000,
    parameter int unsigned GAP_CYCLES   = 1_200_000,
    parameter int unsigned DUTY         = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [2:0] req,
    input  logic [2:0] color0,
    input  logic [2:0] color1,
    input  logic [2:0] color2,
    output logic [2:0] gnt,
    output logic       red,
    output logic       green,
    output logic       blue,
    output logic       busy
);

    // Reject parameter values the 24-bit counters or the 4-bit PWM cannot honour.
    if (DWELL_CYCLES < 2 || DWELL_CYCLES > 32'h00FF_FFFF ||
        GAP_CYCLES   < 1 || GAP_CYCLES   > 32'h00FF_FFFF ||
        DUTY > 16) begin : g_bad_params
        $error("rgb_led_arbiter: parameter out of legal range");
    end

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SERVE = 2'd1,
        GAP   = 2'd2
    } state_t;

    // Counters compare against the last count value, so a phase of N cycles
    // spans counts 0 .. N-1.
    localparam logic [23:0] DWELL_LAST = 24'(DWELL_CYCLES - 1);
    localparam logic [23:0] GAP_LAST   = 24'(GAP_CYCLES - 1);

    state_t      state;
    logic [23:0] dwell_cnt;
    logic [23:0] gap_cnt;
    logic [1:0]  last_granted;
    logic [2:0]  next_gnt;
    logic [2:0]  color_sel;
    logic        led_on;
    logic        released;
    logic        dwell_done;

    // -------------------------------------------------------------------------
    // Round-robin pick: search starts just after the last requester served, so
    // the requester that was served last is considered last.
    // -------------------------------------------------------------------------
    function automatic logic [1:0] rr_next(input logic [1:0] idx);
        return (idx == 2'd2) ? 2'd0 : idx + 2'd1;
    endfunction

    function automatic logic [2:0] rr_pick(input logic [2:0] r, input logic [1:0] last);
        logic [1:0] first;
        logic [1:0] second;
        logic [2:0] pick;
        first  = rr_next(last);
        second = rr_next(first);
        pick   = '0;
        if (r[first])
            pick[first] = 1'b1;
        else if (r[second])
            pick[second] = 1'b1;
        else if (r[last])
            pick[last] = 1'b1;
        return pick;
    endfunction

    function automatic logic [1:0] onehot_to_idx(input logic [2:0] oh);
        logic [1:0] idx;
        idx = 2'd0;
        if (oh[1]) idx = 2'd1;
        if (oh[2]) idx = 2'd2;
        return idx;
    endfunction

    assign next_gnt   = rr_pick(req, last_granted);
    // The granted requester has let go of its request.
    assign released   = ((req & gnt) == 3'b000);
    assign dwell_done = (dwell_cnt == DWELL_LAST);

    // -------------------------------------------------------------------------
    // Arbiter state machine with registered grant.
    // -------------------------------------------------------------------------
    // NOTE: state registers use non-blocking assignments so every flop samples
    // the values from before the edge, independent of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            gnt          <= 3'b000;
            dwell_cnt    <= '0;
            gap_cnt      <= '0;
            last_granted <= 2'd2;
        end else begin
            case (state)
                IDLE: begin
                    if (|req) begin
                        state        <= SERVE;
                        gnt          <= next_gnt;
                        dwell_cnt    <= '0;
                        last_granted <= onehot_to_idx(next_gnt);
                    end
                end

                SERVE: begin
                    // Early release and dwell expiry both end the grant the
                    // same way, so no priority between them is needed here.
                    if (released || dwell_done) begin
                        state   <= GAP;
                        gnt     <= 3'b000;
                        gap_cnt <= '0;
                    end else begin
                        dwell_cnt <= dwell_cnt + 24'd1;
                    end
                end

                GAP: begin
                    // Requests are only looked at on the final gap edge.
                    if (gap_cnt == GAP_LAST) begin
                        if (|req) begin
                            state        <= SERVE;
                            gnt          <= next_gnt;
                            dwell_cnt    <= '0;
                            last_granted <= onehot_to_idx(next_gnt);
                        end else begin
                            state <= IDLE;
                        end
                    end else begin
                        gap_cnt <= gap_cnt + 24'd1;
                    end
                end

                default: begin
                    state <= IDLE;
                    gnt   <= 3'b000;
                end
            endcase
        end
    end

    assign busy = (state != IDLE);

    // -------------------------------------------------------------------------
    // Brightness gate.
    // -------------------------------------------------------------------------
`ifdef LED_DIM_EN
    localparam logic [4:0] DUTY_CMP = 5'(DUTY);

    logic [3:0] pwm_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            pwm_cnt <= 4'd0;
        else
            pwm_cnt <= pwm_cnt + 4'd1;
    end

    // Widened compare so DUTY=16 keeps the LED on for every PWM phase.
    assign led_on = ({1'b0, pwm_cnt} < DUTY_CMP);
`else
    assign led_on = 1'b1;
`endif

    // -------------------------------------------------------------------------
    // LED drive: colour of the granted requester, straight from its inputs so
    // colour changes show up in the same cycle. gnt is one-hot or zero, so an
    // AND-OR mux is enough and gives all-off when nothing is granted.
    // -------------------------------------------------------------------------
    // NOTE: every output of this block is assigned up front so no path leaves
    // it holding a previous value, which would infer a latch.
    always_comb begin
        color_sel = 3'b000;
        color_sel = ({3{gnt[0]}} & color0) |
                    ({3{gnt[1]}} & color1) |
                    ({3{gnt[2]}} & color2);
    end

    assign {red, green, blue} = color_sel & {3{led_on}};

endmodule

// File: doc/rgb_led_arbiter.md
RGB_LED_ARBITER -- requirements
Module: rgb_led_arbiter

Interface
REQ-001 Parameter DWELL_CYCLES, default 12_000_000: maximum grant length in clk cycles (1 s at 12 MHz), legal range 2 to 2^24-1.
REQ-002 Parameter GAP_CYCLES, default 1_200_000: LED-off gap between grants in clk cycles, legal range 1 to 2^24-1.
REQ-003 Parameter DUTY, default 8: on-count out of 16 for dimming, legal range 0 to 16.
REQ-004 clk  input  1  single system clock; all state changes on its rising edge.
REQ-005 rst  input  1  asynchronous, active-high reset.
REQ-006 req  input  3  per-requester active-high request, bit i = requester i.
REQ-007 color0, color1, color2  input  3 each  requested colour {r,g,b}, active-high.
REQ-008 gnt  output  3  one-hot grant, registered.
REQ-009 red, green, blue  output  1 each  active-high LED drive; the top level inverts for the pads.
REQ-010 busy  output  1  high in SERVE or GAP.

Function
REQ-011 States SHALL be IDLE, SERVE and GAP, encoded in registered state.
REQ-012 IDLE: gnt=0 and LEDs off; any req bit high at an edge SHALL enter SERVE with one gnt bit set at that same edge, giving 1-cycle request-to-grant latency.
REQ-013 Arbitration SHALL be round-robin: search order starts at (last_granted+1) mod 3, and last_granted resets to 2 so requester 0 wins first.
REQ-014 SERVE: {red,green,blue} SHALL equal color<k> of the granted k, masked by REQ-024/025, combinationally from the gnt register.
REQ-015 SERVE: a 24-bit dwell counter SHALL clear on grant and increment every cycle.
REQ-016 SERVE SHALL exit to GAP at the edge where req[k]=0 (early release) or the dwell count equals DWELL_CYCLES-1, clearing gnt at that edge; early release takes precedence when both occur.
REQ-017 GAP: LEDs SHALL be off and gnt=0 for exactly GAP_CYCLES cycles, then arbitration SHALL occur as in IDLE: grant into SERVE if any req is high, else go to IDLE.
REQ-018 Requester k whose dwell expired with req still high SHALL be re-granted after GAP only if no other req bit is high.
REQ-019 Changes to color<k> during SERVE SHALL appear on the LEDs in the same cycle; no colour latching.
REQ-020 Requests arriving or dropping during GAP SHALL be sampled only at the end-of-gap edge.
REQ-021 gnt SHALL never have more than one bit set, and busy SHALL equal (state != IDLE).

Reset
REQ-022 While rst=1, asynchronously: state=IDLE, gnt=0, busy=0, red=green=blue=0, dwell and gap counters=0, last_granted=2, PWM counter=0.
REQ-023 Deassertion of rst SHALL take effect at the next clk edge; an active grant at reset assertion is dropped immediately with no GAP.

Configuration
REQ-024 With LED_DIM_EN defined: a free-running 4-bit PWM counter SHALL gate the LEDs, so the colour shows only when pwm_cnt < DUTY; DUTY=16 is always on and DUTY=0 is always off.
REQ-025 Without LED_DIM_EN: no PWM counter SHALL exist, and the colour SHALL show at full duty whenever it is not masked by REQ-014.

Verification (DWELL_CYCLES=8, GAP_CYCLES=2, LED_DIM_EN undefined unless stated)
REQ-026 Reset, then req=001 and color0=100 held -> gnt=001 one edge later, red=1 for 8 cycles, then 2 off cycles with gnt=0, then re-grant gnt=001.
REQ-027 req=111 held, colours 100/010/001 -> grant order 0,1,2,0, each 8 cycles separated by 2-cycle gaps with LEDs off.
REQ-028 req=011 with req[0] dropped in the 3rd SERVE cycle -> GAP starts at that edge, then gnt=010 after 2 cycles.
REQ-029 rst pulsed mid-SERVE (gnt=010) -> gnt=000, LEDs off, busy=0 immediately without waiting for a clk edge; after release with req=111 -> gnt=001 first.
REQ-030 LED_DIM_EN defined, DUTY=4, req=001, color0=111 -> each LED high exactly 4 of every 16 cycles while in SERVE.
REQ-031 All scenarios: an assertion checks that gnt is one-hot or zero every cycle and that LEDs are off whenever gnt=0.
